// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin sync + clock glitch filter, 11-bit frame FSM with bit timeout, show-ahead RX FIFO.
// Latency: pin edge to internal fall strobe SYNC_STAGES+FILTER_LEN+1 cycles; stop-bit fall to FIFO write 1 cycle.
// Backpressure: none toward the PS/2 device; a good frame arriving while full (without a pop) is dropped and flags overflow.
//
// Ports: clk/reset (sync, active-high); ps2_clk/ps2_data raw async pins; rd_en pops the head;
// int_clear clears interrupt/overflow; VPWR/VGND rails only; rd_data/empty/full/count FIFO status;
// parity_err/frame_err one-cycle error strobes; overflow/interrupt sticky flags.
module ps2_rx_fifo #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int BIT_TIMEOUT = CLK_HZ / 5000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          int_clear,
    inout  wire                           VPWR,
    inout  wire                           VGND,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX      = TW'(BIT_TIMEOUT);

    // Power rails carry no logic; fold them into a deliberately unused net.
    wire unused_rails = VPWR ^ VGND;

    // ---------------- pin synchronisers ----------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   data_s;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // ---------------- glitch filter and fall detect ----------------
    logic          fclk;
    logic          fclk_d;
    logic          fall;
    logic [FW-1:0] filt_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            fclk     <= 1'b1;
            fclk_d   <= 1'b1;
            fall     <= 1'b0;
            filt_cnt <= '0;
        end else begin
            fclk_d <= fclk;
            fall   <= fclk_d & ~fclk;
            // Count consecutive samples that disagree with fclk; any agreeing sample restarts the count.
            if (clk_s == fclk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                fclk     <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // ---------------- frame FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          par_ok;
    logic          push;

    // A fall in the same cycle as the timer expiring still counts as a valid bit.
    assign timeout = (state != S_IDLE) && !fall && (timer == TMAX);
    assign par_ok  = ^{shreg, par_bit};
    assign push    = fall && (state == S_STOP) && data_s && par_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_IDLE || fall) begin
                timer <= '0;
            end else if (timer != TMAX) begin
                timer <= timer + 1'b1;
            end

            if (timeout) begin
                state     <= S_IDLE;
                shreg     <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!data_s) begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= data_s;
                        state   <= S_STOP;
                    end
                    default: begin
                        // Stop-bit error takes precedence over a parity error.
                        if (!data_s) begin
                            frame_err <= 1'b1;
                        end else if (!par_ok) begin
                            parity_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- receive FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] prev_ptr;
    logic          do_pop;
    logic          do_push;
    logic          ovf_evt;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = rd_en && !empty;
    assign do_push  = push && (!full || do_pop);
    assign ovf_evt  = push && full && !do_pop;
    assign prev_ptr = rd_ptr - 1'b1;
    // While empty, show the most recently popped byte so rd_data holds its last value.
    assign rd_data  = empty ? mem[prev_ptr] : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            interrupt <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (do_push) begin
                interrupt <= 1'b1;
            end else if (int_clear) begin
                interrupt <= 1'b0;
            end

            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (int_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: table of single frames plus hand-written multi-frame sequences.
// PS/2 clock is 12.5 kHz relative to a 250 kHz system clock (20 system cycles per bit).
// All expected values are hand-computed constants.
module tb_ps2_rx_fifo;

    localparam int CLK_HZ      = 250_000;
    localparam int BIT_TIMEOUT = CLK_HZ / 5000;   // 50 cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       int_clear = 1'b0;
    wire        vpwr;
    wire        vgnd;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       interrupt;

    assign vpwr = 1'b1;
    assign vgnd = 1'b0;

    int checks = 0;
    int errors = 0;
    int perr_cycles = 0;
    int ferr_cycles = 0;

    ps2_rx_fifo #(
        .CLK_HZ      (CLK_HZ),
        .BIT_TIMEOUT (BIT_TIMEOUT),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .int_clear  (int_clear),
        .VPWR       (vpwr),
        .VGND       (vgnd),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .interrupt  (interrupt)
    );

    always #5 clk = ~clk;

    // Count cycles each error strobe is high: one clean pulse adds exactly 1.
    always @(posedge clk) begin
        if (parity_err) perr_cycles++;
        if (frame_err)  ferr_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data set while clock high, clock low 10 cycles, high 10 cycles.
    // The FIFO write for a stop bit lands on the 8th rising edge after the clock pin falls
    // (7 cycles to the fall strobe, 1 more to the write); rd_en/int_clear can be aimed at it.
    task automatic ps2_bit(input logic b, input logic pop_at_push, input logic clr_at_push);
        @(negedge clk) ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_at_push || clr_at_push) begin
            repeat (7) @(negedge clk);
            rd_en     = pop_at_push;
            int_clear = clr_at_push;
            @(negedge clk);
            rd_en     = 1'b0;
            int_clear = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] dat, input logic par_flip, input logic stop,
                              input logic pop_at_push, input logic clr_at_push);
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(dat[i], 1'b0, 1'b0);
        ps2_bit(~(^dat) ^ par_flip, 1'b0, 1'b0);
        ps2_bit(stop, pop_at_push, clr_at_push);
        repeat (10) @(negedge clk);
    endtask

    // Start bit plus the first n_data data bits, then the line goes quiet.
    task automatic send_partial(input logic [7:0] dat, input int n_data);
        ps2_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n_data; i++) ps2_bit(dat[i], 1'b0, 1'b0);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic clear_irq();
        @(negedge clk) int_clear = 1'b1;
        @(negedge clk) int_clear = 1'b0;
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       par_flip;
        logic       stop;
        logic       exp_push;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int pb;
        int fb;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};  // good frame, parity 0
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 0};  // parity wrong
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0, 1};  // bad stop bit
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0, 0};  // all ones, parity 1
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 0};  // all zeros, parity 1
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 0, 1};  // bad stop outranks bad parity

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);

        // ---------------- single-frame table ----------------
        for (int v = 0; v < 6; v++) begin
            clear_irq();
            pb = perr_cycles;
            fb = ferr_cycles;
            send_frame(vecs[v].dat, vecs[v].par_flip, vecs[v].stop, 1'b0, 1'b0);
            check($sformatf("vec%0d_count", v), count, {31'd0, vecs[v].exp_push});
            check($sformatf("vec%0d_empty", v), empty, {31'd0, ~vecs[v].exp_push});
            check($sformatf("vec%0d_interrupt", v), interrupt, {31'd0, vecs[v].exp_push});
            check($sformatf("vec%0d_parity_err", v), perr_cycles - pb, vecs[v].exp_perr);
            check($sformatf("vec%0d_frame_err", v), ferr_cycles - fb, vecs[v].exp_ferr);
            if (vecs[v].exp_push) begin
                check($sformatf("vec%0d_rd_data", v), rd_data, {24'd0, vecs[v].dat});
                pop();
                check($sformatf("vec%0d_empty_after_pop", v), empty, 1);
                check($sformatf("vec%0d_hold_after_pop", v), rd_data, {24'd0, vecs[v].dat});
            end
        end

        // ---------------- bad start bit ----------------
        fb = ferr_cycles;
        ps2_bit(1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("bad_start_frame_err", ferr_cycles - fb, 1);
        check("bad_start_count", count, 0);

        // ---------------- timeout mid-frame ----------------
        clear_irq();
        fb = ferr_cycles;
        pb = perr_cycles;
        send_partial(8'hF0, 4);
        repeat (BIT_TIMEOUT + 30) @(negedge clk);
        check("timeout_frame_err", ferr_cycles - fb, 1);
        check("timeout_parity_err", perr_cycles - pb, 0);
        check("timeout_count", count, 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_timeout_count", count, 1);
        check("after_timeout_rd_data", rd_data, 8'hF0);
        check("after_timeout_frame_err", ferr_cycles - fb, 1);
        pop();

        // ---------------- glitch filter ----------------
        clear_irq();
        fb = ferr_cycles;
        pb = perr_cycles;
        @(negedge clk) ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_frame_err", ferr_cycles - fb, 0);
        check("glitch_parity_err", perr_cycles - pb, 0);
        check("glitch_count", count, 0);
        check("glitch_interrupt", interrupt, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_glitch_rd_data", rd_data, 8'h3C);
        check("after_glitch_frame_err", ferr_cycles - fb, 0);
        pop();

        // ---------------- overflow ----------------
        clear_irq();
        for (int i = 1; i <= 9; i++) send_frame(i[7:0], 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovf_full", full, 1);
        check("ovf_count", count, 8);
        check("ovf_overflow", overflow, 1);
        check("ovf_interrupt", interrupt, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_read%0d", i), rd_data, i);
            pop();
        end
        check("ovf_drained_empty", empty, 1);
        check("ovf_drained_hold", rd_data, 8'h08);
        check("ovf_overflow_sticky", overflow, 1);
        clear_irq();
        check("ovf_cleared", overflow, 0);
        check("irq_cleared", interrupt, 0);

        // ---------------- simultaneous push/pop when full ----------------
        for (int i = 0; i < 8; i++) send_frame(8'h11 + i[7:0], 1'b0, 1'b1, 1'b0, 1'b0);
        check("refill_full", full, 1);
        send_frame(8'h19, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pp_full_count", count, 8);
        check("pp_full_overflow", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_read%0d", i), rd_data, 8'h12 + i);
            pop();
        end
        check("pp_drained_empty", empty, 1);

        // ---------------- simultaneous push/pop when empty ----------------
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pp_empty_count", count, 1);
        check("pp_empty_rd_data", rd_data, 8'h5A);
        pop();

        // ---------------- int_clear on the push cycle ----------------
        clear_irq();
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_vs_push_interrupt", interrupt, 1);
        check("clr_vs_push_count", count, 1);

        // ---------------- reset mid-frame ----------------
        fb = ferr_cycles;
        pb = perr_cycles;
        send_partial(8'hAA, 4);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_interrupt", interrupt, 0);
        check("midrst_overflow", overflow, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_rst_count", count, 1);
        check("after_rst_rd_data", rd_data, 8'hAA);
        check("after_rst_frame_err", ferr_cycles - fb, 0);
        check("after_rst_parity_err", perr_cycles - pb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
